// File: rtl/t07_tft_cmdq_if.sv
// Command-queue bus between the TFT memory handler, the queue and the SPI serializer.
// Latency: none, wires only; the queue owns all timing.
// Backpressure: full_o/empty_o status plus busy_i handshake from the serializer.
interface t07_tft_cmdq_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          push_i;
  logic [31:0]   addr_i;
  logic [31:0]   data_i;
  logic          flush_i;
  logic          busy_i;
  logic          wi_o;
  logic [31:0]   address_o;
  logic [31:0]   data_o;
  logic          full_o;
  logic          empty_o;
  logic [CW-1:0] count_o;
  logic          overflow_o;
  logic          timeout_o;

  // Queue side
  modport slave (
    input  push_i, addr_i, data_i, flush_i, busy_i,
    output wi_o, address_o, data_o, full_o, empty_o, count_o, overflow_o, timeout_o
  );

  // Memory-handler / serializer side
  modport master (
    output push_i, addr_i, data_i, flush_i, busy_i,
    input  wi_o, address_o, data_o, full_o, empty_o, count_o, overflow_o, timeout_o
  );
endinterface

// File: rtl/t07_tft_cmdq.sv
// Circular command queue feeding TFT register writes to the SPI serializer, one at a time.
// Latency: push to wi_o rising is 2 cycles from an empty/idle queue; one GAP cycle between commands.
// Backpressure: pushes while full are dropped (sticky overflow_o); drain paced by busy_i with timeout.
module t07_tft_cmdq #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 8
) (
  input  logic              clk,
  input  logic              nrst,
  t07_tft_cmdq_if.slave     bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  cmd_t          r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  state_t        r_state;
  logic          r_seen_busy;
  logic [TW-1:0] r_tcnt;
  logic          r_overflow;
  logic          r_timeout;

  logic w_full;
  logic w_empty;
  logic w_done;
  logic w_tout;
  logic w_pop;
  logic w_push_ok;
  logic w_push_drop;
  cmd_t w_head;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);

  // Serializer finished: it was seen busy and has now dropped busy.
  assign w_done  = (r_state == ST_SEND) && r_seen_busy && !bus.busy_i;
  // Serializer never acknowledged within the allowed SEND cycles.
  assign w_tout  = (r_state == ST_SEND) && !r_seen_busy && (r_tcnt == TW'(TIMEOUT));

  // Flush overrides every queue update in its cycle.
  assign w_pop       = (w_done || w_tout) && !bus.flush_i;
  assign w_push_ok   = bus.push_i && !w_full && !bus.flush_i;
  assign w_push_drop = bus.push_i &&  w_full && !bus.flush_i;

  assign w_head = r_mem[r_rptr];

  // wi_o is combinational so it can drop in the completion/timeout/flush cycle itself.
  assign bus.wi_o       = (r_state == ST_SEND) && !w_done && !w_tout && !bus.flush_i;
  assign bus.address_o  = w_head.addr;
  assign bus.data_o     = w_head.data;
  assign bus.full_o     = w_full;
  assign bus.empty_o    = w_empty;
  assign bus.count_o    = r_count;
  assign bus.overflow_o = r_overflow;
  assign bus.timeout_o  = r_timeout;

  // Entry storage; cleared on reset so the head outputs read zero.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push_ok) begin
      r_mem[r_wptr] <= '{addr: bus.addr_i, data: bus.data_i};
    end
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (bus.flush_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky error flags; only reset clears them, flush leaves them alone.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_overflow <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      if (w_push_drop) begin
        r_overflow <= 1'b1;
      end
      if (w_tout && !bus.flush_i) begin
        r_timeout <= 1'b1;
      end
    end
  end

  // Drain FSM: IDLE waits for work, SEND holds wi_o until busy completes or times out, GAP forces wi low.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state     <= ST_IDLE;
      r_seen_busy <= 1'b0;
      r_tcnt      <= '0;
    end else if (bus.flush_i) begin
      r_state     <= (r_state == ST_SEND) ? ST_GAP : ST_IDLE;
      r_seen_busy <= 1'b0;
      r_tcnt      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_seen_busy <= 1'b0;
          r_tcnt      <= '0;
          if (!w_empty) begin
            r_state <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (w_done || w_tout) begin
            r_state     <= ST_GAP;
            r_seen_busy <= 1'b0;
            r_tcnt      <= '0;
          end else begin
            if (bus.busy_i) begin
              r_seen_busy <= 1'b1;
            end
            // Counter only matters until busy is seen; freezing it keeps it bounded.
            if (!r_seen_busy) begin
              r_tcnt <= r_tcnt + 1'b1;
            end
          end
        end
        ST_GAP: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_t07_tft_cmdq.sv
// Directed bench for the TFT command queue with a cycle-level serializer model.
// Latency: checks sampled 1 time unit after each falling edge.
// Backpressure: busy_i driven by the model (rises 2 cycles after wi, high 64 cycles).
module tb_t07_tft_cmdq;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 8;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  t07_tft_cmdq_if #(.DEPTH(DEPTH)) bus ();

  t07_tft_cmdq #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Serializer model state: ser_t is the cycle index since wi was first seen high.
  bit  ser_on    = 1'b0;
  int  ser_t     = -1;
  bit  prev_busy = 1'b0;
  // Issue log
  bit  prev_wi   = 1'b0;
  int  rises     = 0;
  int  stab_err  = 0;
  logic [31:0] held_addr = '0;
  logic [31:0] held_data = '0;
  logic [31:0] iss_addr[$];
  logic [31:0] iss_data[$];

  task automatic step(input bit p = 1'b0, input logic [31:0] a = '0,
                      input logic [31:0] d = '0, input bit f = 1'b0);
    @(negedge clk);
    bus.push_i  = p;
    bus.addr_i  = a;
    bus.data_i  = d;
    bus.flush_i = f;
    prev_busy   = bus.busy_i;
    if (ser_t >= 0) ser_t++;
    if (ser_t > 65) begin
      bus.busy_i = 1'b0;
      ser_t      = -1;
    end else begin
      bus.busy_i = ser_on && (ser_t >= 2);
    end
    #1;
    if (ser_on && ser_t < 0 && bus.wi_o) ser_t = 0;
    if (bus.wi_o && !prev_wi) begin
      rises++;
      iss_addr.push_back(bus.address_o);
      iss_data.push_back(bus.data_o);
    end
    if (bus.wi_o && prev_wi && (bus.address_o !== held_addr || bus.data_o !== held_data)) stab_err++;
    held_addr = bus.address_o;
    held_data = bus.data_o;
    prev_wi   = bus.wi_o;
  endtask

  task automatic drain(input int bound, output bit ok);
    int quiet;
    quiet = 0;
    ok    = 1'b0;
    for (int i = 0; i < bound; i++) begin
      step();
      if (bus.empty_o && !bus.wi_o) quiet++; else quiet = 0;
      if (quiet >= 3) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_checks++; if (bus.wi_o !== 1'b0) begin n_fail++; $display("FAIL reset_wi: got %b want 0", bus.wi_o); end
    n_checks++; if (bus.empty_o !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", bus.empty_o); end
    n_checks++; if (bus.full_o !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", bus.full_o); end
    n_checks++; if (bus.count_o !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", bus.count_o); end
    n_checks++; if (bus.overflow_o !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", bus.overflow_o); end
    n_checks++; if (bus.timeout_o !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b want 0", bus.timeout_o); end
    n_checks++; if (bus.address_o !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", bus.address_o); end
    n_checks++; if (bus.data_o !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", bus.data_o); end
    @(negedge clk);
    nrst = 1'b1;
    step();
    n_checks++; if (bus.wi_o !== 1'b0 || bus.empty_o !== 1'b1) begin n_fail++; $display("FAIL post_reset_idle: got wi=%b empty=%b want 0/1", bus.wi_o, bus.empty_o); end
  endtask

  task automatic test_single();
    int k;
    int r0;
    ser_on = 1'b1;
    r0 = rises;
    step(1'b1, 32'h0000_0088, 32'h0000_000A);
    n_checks++; if (bus.wi_o !== 1'b0) begin n_fail++; $display("FAIL single_wi_push_cycle: got %b want 0", bus.wi_o); end
    k = 0;
    while (!bus.wi_o && k < 4) begin step(); k++; end
    n_checks++; if (bus.wi_o !== 1'b1) begin n_fail++; $display("FAIL single_wi_rise: got %b want 1", bus.wi_o); end
    n_checks++; if (bus.address_o !== 32'h88 || bus.data_o !== 32'hA) begin n_fail++; $display("FAIL single_head: got %h/%h want 88/a", bus.address_o, bus.data_o); end
    k = 0;
    while (bus.wi_o && k < 100) begin step(); k++; end
    // busy high at rise+2..rise+65, wi drops in the cycle busy falls (rise+66)
    n_checks++; if (k !== 66) begin n_fail++; $display("FAIL single_wi_high_len: got %0d want 66", k); end
    n_checks++; if (bus.busy_i !== 1'b0 || prev_busy !== 1'b1) begin n_fail++; $display("FAIL single_fall_on_busy: got busy=%b prev=%b want 0/1", bus.busy_i, prev_busy); end
    step();
    n_checks++; if (bus.wi_o !== 1'b0) begin n_fail++; $display("FAIL single_gap_wi: got %b want 0", bus.wi_o); end
    step();
    n_checks++; if (bus.empty_o !== 1'b1 || bus.count_o !== 3'd0) begin n_fail++; $display("FAIL single_empty: got empty=%b count=%0d want 1/0", bus.empty_o, bus.count_o); end
    n_checks++; if (bus.timeout_o !== 1'b0) begin n_fail++; $display("FAIL single_timeout: got %b want 0", bus.timeout_o); end
    n_checks++; if (rises - r0 !== 1) begin n_fail++; $display("FAIL single_pulses: got %0d want 1", rises - r0); end
  endtask

  task automatic test_back_to_back();
    int r0;
    int q0;
    bit ok;
    logic [31:0] ea;
    logic [31:0] ed;
    r0 = rises;
    q0 = iss_addr.size();
    for (int i = 0; i < 4; i++) step(1'b1, 32'h0000_0100 + 32'(i * 4), 32'hCAFE_0000 + 32'(i));
    step(1'b1, 32'h0000_0DEAD, 32'hDEAD_BEEF);
    n_checks++; if (bus.full_o !== 1'b1 || bus.count_o !== 3'd4) begin n_fail++; $display("FAIL b2b_full: got full=%b count=%0d want 1/4", bus.full_o, bus.count_o); end
    n_checks++; if (bus.overflow_o !== 1'b0) begin n_fail++; $display("FAIL b2b_overflow_pre: got %b want 0", bus.overflow_o); end
    step();
    n_checks++; if (bus.overflow_o !== 1'b1 || bus.count_o !== 3'd4) begin n_fail++; $display("FAIL b2b_overflow: got ovf=%b count=%0d want 1/4", bus.overflow_o, bus.count_o); end
    drain(800, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL b2b_drain_bound: got %b want 1", ok); end
    n_checks++; if (rises - r0 !== 4) begin n_fail++; $display("FAIL b2b_pulses: got %0d want 4", rises - r0); end
    for (int i = 0; i < 4; i++) begin
      ea = 32'h0000_0100 + 32'(i * 4);
      ed = 32'hCAFE_0000 + 32'(i);
      n_checks++;
      if (iss_addr.size() <= q0 + i || iss_addr[q0 + i] !== ea || iss_data[q0 + i] !== ed) begin
        n_fail++; $display("FAIL b2b_order_%0d: got issue count %0d, want %h/%h", i, iss_addr.size() - q0, ea, ed);
      end
    end
    n_checks++; if (bus.count_o !== 3'd0) begin n_fail++; $display("FAIL b2b_count_end: got %0d want 0", bus.count_o); end
    n_checks++; if (stab_err !== 0) begin n_fail++; $display("FAIL b2b_head_stable: got %0d changes want 0", stab_err); end
  endtask

  task automatic test_push_during_drain();
    int k;
    int r0;
    int q0;
    bit ok;
    r0 = rises;
    q0 = iss_addr.size();
    step(1'b1, 32'h0000_0200, 32'h0000_00B0);
    k = 0;
    while (ser_t != 65 && k < 100) begin step(); k++; end
    n_checks++; if (bus.wi_o !== 1'b1 || bus.count_o !== 3'd1) begin n_fail++; $display("FAIL drain_pre: got wi=%b count=%0d want 1/1", bus.wi_o, bus.count_o); end
    step(1'b1, 32'h0000_0204, 32'h0000_00B1);
    n_checks++; if (bus.wi_o !== 1'b0) begin n_fail++; $display("FAIL drain_complete_wi: got %b want 0", bus.wi_o); end
    step();
    n_checks++; if (bus.count_o !== 3'd1 || bus.wi_o !== 1'b0) begin n_fail++; $display("FAIL drain_count_kept: got count=%0d wi=%b want 1/0", bus.count_o, bus.wi_o); end
    step();
    n_checks++; if (bus.wi_o !== 1'b0) begin n_fail++; $display("FAIL drain_idle_wi: got %b want 0", bus.wi_o); end
    step();
    n_checks++; if (bus.wi_o !== 1'b1 || bus.address_o !== 32'h204 || bus.data_o !== 32'hB1) begin n_fail++; $display("FAIL drain_next_issue: got wi=%b %h/%h want 1 204/b1", bus.wi_o, bus.address_o, bus.data_o); end
    drain(200, ok);
    n_checks++; if (ok !== 1'b1 || rises - r0 !== 2) begin n_fail++; $display("FAIL drain_end: got ok=%b pulses=%0d want 1/2", ok, rises - r0); end
    n_checks++; if (iss_addr.size() < q0 + 2 || iss_addr[q0] !== 32'h200) begin n_fail++; $display("FAIL drain_first: got issue count %0d want 200 first", iss_addr.size() - q0); end
  endtask

  task automatic test_timeout();
    int k;
    int hi;
    int r0;
    ser_on = 1'b0;
    step(1'b1, 32'h0000_0300, 32'h0000_00C0);
    k = 0;
    while (!bus.wi_o && k < 4) begin step(); k++; end
    r0 = rises;
    hi = 0;
    while (bus.wi_o && hi < 20) begin hi++; step(); end
    n_checks++; if (hi !== TIMEOUT) begin n_fail++; $display("FAIL tout_send_len: got %0d want %0d", hi, TIMEOUT); end
    n_checks++; if (bus.timeout_o !== 1'b0 || bus.count_o !== 3'd1) begin n_fail++; $display("FAIL tout_cycle: got tout=%b count=%0d want 0/1", bus.timeout_o, bus.count_o); end
    step();
    n_checks++; if (bus.timeout_o !== 1'b1 || bus.count_o !== 3'd0 || bus.wi_o !== 1'b0) begin n_fail++; $display("FAIL tout_gap: got tout=%b count=%0d wi=%b want 1/0/0", bus.timeout_o, bus.count_o, bus.wi_o); end
    step();
    n_checks++; if (bus.empty_o !== 1'b1 || bus.wi_o !== 1'b0) begin n_fail++; $display("FAIL tout_idle: got empty=%b wi=%b want 1/0", bus.empty_o, bus.wi_o); end
    repeat (5) step();
    n_checks++; if (rises !== r0) begin n_fail++; $display("FAIL tout_no_reissue: got %0d extra pulses want 0", rises - r0); end
  endtask

  task automatic test_flush();
    int r0;
    ser_on = 1'b1;
    r0 = rises;
    step(1'b1, 32'h0000_0400, 32'h0000_00D0);
    step(1'b1, 32'h0000_0404, 32'h0000_00D1);
    step(1'b1, 32'h0000_0408, 32'h0000_00D2);
    step();
    n_checks++; if (bus.count_o !== 3'd3 || bus.wi_o !== 1'b1) begin n_fail++; $display("FAIL flush_pre: got count=%0d wi=%b want 3/1", bus.count_o, bus.wi_o); end
    step(1'b1, 32'h0000_040C, 32'h0000_00D3, 1'b1);
    n_checks++; if (bus.wi_o !== 1'b0) begin n_fail++; $display("FAIL flush_cycle_wi: got %b want 0", bus.wi_o); end
    step();
    n_checks++; if (bus.count_o !== 3'd0 || bus.empty_o !== 1'b1) begin n_fail++; $display("FAIL flush_count: got count=%0d empty=%b want 0/1", bus.count_o, bus.empty_o); end
    n_checks++; if (bus.overflow_o !== 1'b1 || bus.timeout_o !== 1'b1) begin n_fail++; $display("FAIL flush_sticky: got ovf=%b tout=%b want 1/1", bus.overflow_o, bus.timeout_o); end
    repeat (80) step();
    n_checks++; if (rises - r0 !== 1 || bus.count_o !== 3'd0) begin n_fail++; $display("FAIL flush_quiet: got pulses=%0d count=%0d want 1/0", rises - r0, bus.count_o); end
  endtask

  task automatic test_reset_mid_send();
    int k;
    bit ok;
    ser_on = 1'b1;
    step(1'b1, 32'h0000_0500, 32'h0000_00E0);
    step(1'b1, 32'h0000_0504, 32'h0000_00E1);
    step();
    step();
    n_checks++; if (bus.wi_o !== 1'b1) begin n_fail++; $display("FAIL rst_pre_send: got %b want 1", bus.wi_o); end
    #2 nrst = 1'b0;
    #1;
    n_checks++; if (bus.wi_o !== 1'b0) begin n_fail++; $display("FAIL rst_async_wi: got %b want 0", bus.wi_o); end
    n_checks++; if (bus.count_o !== 3'd0 || bus.empty_o !== 1'b1 || bus.full_o !== 1'b0) begin n_fail++; $display("FAIL rst_status: got count=%0d empty=%b full=%b want 0/1/0", bus.count_o, bus.empty_o, bus.full_o); end
    n_checks++; if (bus.overflow_o !== 1'b0 || bus.timeout_o !== 1'b0) begin n_fail++; $display("FAIL rst_flags: got ovf=%b tout=%b want 0/0", bus.overflow_o, bus.timeout_o); end
    n_checks++; if (bus.address_o !== 32'h0 || bus.data_o !== 32'h0) begin n_fail++; $display("FAIL rst_head: got %h/%h want 0/0", bus.address_o, bus.data_o); end
    ser_t      = -1;
    bus.busy_i = 1'b0;
    prev_wi    = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    step(1'b1, 32'h0000_0600, 32'h0000_00F0);
    k = 0;
    while (!bus.wi_o && k < 4) begin step(); k++; end
    n_checks++; if (bus.wi_o !== 1'b1 || bus.address_o !== 32'h600 || bus.data_o !== 32'hF0) begin n_fail++; $display("FAIL rst_resume: got wi=%b %h/%h want 1 600/f0", bus.wi_o, bus.address_o, bus.data_o); end
    drain(200, ok);
    n_checks++; if (ok !== 1'b1 || bus.count_o !== 3'd0 || bus.timeout_o !== 1'b0) begin n_fail++; $display("FAIL rst_resume_drain: got ok=%b count=%0d tout=%b want 1/0/0", ok, bus.count_o, bus.timeout_o); end
  endtask

  initial begin
    bus.push_i  = 1'b0;
    bus.addr_i  = '0;
    bus.data_i  = '0;
    bus.flush_i = 1'b0;
    bus.busy_i  = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_push_during_drain();
    test_timeout();
    test_flush();
    test_reset_mid_send();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/t07_tft_cmdq.md
T07_TFT_CMDQ -- requirements
Module: t07_tft_cmdq

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of command queue entries (power of two, 2..16).
REQ-002 SHALL have parameter TIMEOUT, default 8, meaning the number of SEND cycles allowed for busy_i to rise.
REQ-003 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-004 SHALL have port nrst, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port push_i, input, 1 bit: the memory handler offers a write command this cycle.
REQ-006 SHALL have port addr_i, input, 32 bits: register address for the TFT write.
REQ-007 SHALL have port data_i, input, 32 bits: register data for the TFT write.
REQ-008 SHALL have port flush_i, input, 1 bit: discard all queued entries and abort the drain.
REQ-009 SHALL have port busy_i, input, 1 bit: busy from the SPI TFT serializer.
REQ-010 SHALL have port wi_o, output, 1 bit: write-in request to the serializer.
REQ-011 SHALL have port address_o, output, 32 bits: address of the head entry, to the serializer.
REQ-012 SHALL have port data_o, output, 32 bits: data of the head entry, to the serializer.
REQ-013 SHALL have ports full_o, empty_o, output, 1 bit each: queue status.
REQ-014 SHALL have port count_o, output, $clog2(DEPTH)+1 bits: number of occupied entries.
REQ-015 SHALL have ports overflow_o, timeout_o, output, 1 bit each: sticky error flags.

Function
REQ-016 SHALL implement a circular FIFO of DEPTH entries of {addr, data}, with read and write pointers that wrap modulo DEPTH.
REQ-017 SHALL write an entry on a rising edge when push_i=1 and full_o=0; count increments by one unless a pop occurs in the same cycle, in which case count is unchanged.
REQ-018 SHALL drop the command when push_i=1 and full_o=1 (also when a pop occurs in the same cycle), and set overflow_o.
REQ-019 SHALL drive address_o/data_o from the head entry continuously; these outputs are held stable for the whole SEND state.
REQ-020 SHALL implement an FSM with states IDLE, SEND and GAP.
REQ-021 IDLE: wi_o=0; go to SEND when empty_o=0 and flush_i=0.
REQ-022 SEND: wi_o=1 except in the completion cycle; an internal seen_busy flag sets on any cycle with busy_i=1.
REQ-023 SEND completion: when seen_busy=1 and busy_i=0, the block SHALL drive wi_o=0 combinationally in that same cycle, pop the head entry at the edge, clear seen_busy, and go to GAP.
REQ-024 SEND timeout: a cycle counter starts at 0 on SEND entry; if it reaches TIMEOUT with seen_busy=0, the block SHALL set timeout_o, pop the head entry, drive wi_o=0 that cycle, and go to GAP.
REQ-025 GAP: wi_o=0 for exactly one cycle, then go to IDLE; this guarantees the serializer sees wi low between commands.
REQ-026 flush_i=1 SHALL, at the edge, reset both pointers and count to 0, clear seen_busy, and force the FSM to GAP (from SEND) or IDLE (otherwise); wi_o=0 in the flush cycle; flush wins over a simultaneous push.
REQ-027 full_o SHALL equal (count==DEPTH) and empty_o SHALL equal (count==0); both are derived from registered count.
REQ-028 overflow_o and timeout_o SHALL clear only on reset; flush_i does not clear them.
REQ-029 Commands SHALL be issued strictly in push order, with no duplication and no reordering.

Reset
REQ-030 On nrst=0 the block SHALL immediately force: FSM=IDLE, pointers=0, count_o=0, empty_o=1, full_o=0, wi_o=0, overflow_o=0, timeout_o=0, seen_busy=0, timeout counter=0; address_o/data_o=0.
REQ-031 Reset asserted mid-SEND SHALL drop wi_o within the same cycle and lose all queued entries.

Verification
REQ-032 Single command: push addr=0x00000088, data=0x0000000A; model the serializer (busy rises 2 cycles after wi, stays high 64 cycles). Required: wi_o high from the cycle after push until busy falls, one GAP cycle, empty_o=1, timeout_o=0.
REQ-033 Back-to-back: push 4 commands in 4 consecutive cycles. Required: full_o=1 after the 4th push, a 5th push sets overflow_o, the 4 commands issue in order, wi_o is low for at least 1 cycle between commands, count_o ends at 0.
REQ-034 Push during drain: push while in SEND with count=1. Required: count stays 1 across the pop edge; the next command issues after GAP.
REQ-035 Timeout: hold busy_i=0 with one entry queued. Required: timeout_o=1 after TIMEOUT=8 SEND cycles, entry popped, FSM back in IDLE after GAP.
REQ-036 Flush mid-SEND with 3 entries queued (push asserted in the same cycle). Required: count_o=0 next cycle, wi_o=0 in the flush cycle, the pushed command is discarded, no further wi_o pulse.
REQ-037 Reset mid-SEND. Required: wi_o=0 asynchronously, all outputs at their REQ-030 values, and normal operation on the first push after release.
